// File: rtl/audio_link_ctrl.sv
// audio_link_ctrl: bring-up sequencer and stream scheduler for the full-duplex
// audio path (ADC I2S -> UDP TX, UDP RX -> DAC I2S).
//   - Holds codec config and Ethernet stack in reset until the PLL is locked.
//   - Supervises codec init / link-up with a timeout and bounded retries.
//   - Gates TX framing and RX read enable on a debounced headset-present state.
//   - Re-sequences the path on jack removal or on loss of lock, init or link.
// Optional feature macro: AUDIO_LINK_AUTO_RECOVER_EN
//   defined   -> FAULT waits FAULT_WAIT_CYC cycles, then retries from RESET_HOLD
//   undefined -> FAULT is sticky until sys_rst, no FAULT dwell counting
// All outputs are registered; they are decoded from the next state so that
// they change on the same edge as state_o.

module audio_link_ctrl #(
    parameter int unsigned DEBOUNCE_CYC     = 32'd500000,
    parameter int unsigned HOLD_CYC         = 32'd65536,
    parameter int unsigned INIT_TIMEOUT_CYC = 32'd50000000,
    parameter int unsigned RETRY_MAX        = 32'd3,
    parameter int unsigned FAULT_WAIT_CYC   = 32'd250000000
) (
    input  logic       clk_50M,
    input  logic       sys_rst,
    input  logic       pll_locked,
    input  logic       codec_init_done,
    input  logic       eth_link_up,
    input  logic       lin_detect,
    input  logic       lout_detect,
    input  logic       rx_data_ready,
    output logic       codec_rst_n,
    output logic       eth_rst_n,
    output logic       tx_enable,
    output logic       rx_rd_en,
    output logic       insert_detect_led,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_INIT       = 3'd1,
        ST_WAIT_JACK  = 3'd2,
        ST_PRIME      = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    // Parameter sanity: reject configurations the counters cannot represent.
    if ((DEBOUNCE_CYC < 32'd2) || (HOLD_CYC < 32'd1) || (INIT_TIMEOUT_CYC < 32'd1) ||
        (RETRY_MAX > 32'd3) || (FAULT_WAIT_CYC < 32'd1)) begin : g_bad_param
        $error("audio_link_ctrl: illegal parameter combination");
    end

    // Shared timer is sized for the longest interval it has to measure; the
    // FAULT dwell only contributes when auto-recovery is built in.
    localparam int unsigned TMR_A    = (HOLD_CYC > INIT_TIMEOUT_CYC) ? HOLD_CYC : INIT_TIMEOUT_CYC;
`ifdef AUDIO_LINK_AUTO_RECOVER_EN
    localparam int unsigned TMR_SPAN = (FAULT_WAIT_CYC > TMR_A) ? FAULT_WAIT_CYC : TMR_A;
`else
    localparam int unsigned TMR_SPAN = TMR_A;
`endif
    localparam int unsigned TMR_W    = $clog2(TMR_SPAN + 32'd1);
    localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYC + 32'd1);

    localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYC - 32'd1);
    localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_TIMEOUT_CYC - 32'd1);
`ifdef AUDIO_LINK_AUTO_RECOVER_EN
    localparam logic [TMR_W-1:0] FAULT_LAST = TMR_W'(FAULT_WAIT_CYC - 32'd1);
`endif
    localparam logic [DEB_W-1:0] DEB_ZERO   = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(32'd1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 32'd1);
    localparam logic [1:0]       RETRY_LAST = 2'(RETRY_MAX);

    // Synchroniser bit map: {rx_ready, lout, lin, link, codec_done, pll}.
    // Jack detects are active-low, so they reset to "absent" (1).
    localparam logic [5:0] SYNC_RST = 6'b011000;

    logic [5:0]       sync_in_s;
    logic [5:0]       sync_q1_r;
    logic [5:0]       sync_q2_r;
    logic             pll_sync_s;
    logic             codec_done_sync_s;
    logic             link_sync_s;
    logic             lin_sync_s;
    logic             lout_sync_s;
    logic             rx_ready_sync_s;
    logic             raw_present_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             jack_present_r;
    state_t           state_r;
    state_t           state_nx_s;
    logic [TMR_W-1:0] tmr_r;
    logic [TMR_W-1:0] tmr_nx_s;
    logic             tmr_run_s;
    logic [1:0]       retry_cnt_r;
    logic [1:0]       retry_nx_s;
    logic             codec_rst_n_r;
    logic             eth_rst_n_r;
    logic             tx_enable_r;
    logic             rx_rd_en_r;
    logic             fault_r;
    logic             stream_ok_s;

    assign sync_in_s = {rx_data_ready, lout_detect, lin_detect,
                        eth_link_up, codec_init_done, pll_locked};

    // Two-flop synchroniser for every asynchronous / foreign-domain input.
    always_ff @(posedge clk_50M or negedge sys_rst) begin
        if (!sys_rst) begin
            sync_q1_r <= SYNC_RST;
            sync_q2_r <= SYNC_RST;
        end else begin
            sync_q1_r <= sync_in_s;
            sync_q2_r <= sync_q1_r;
        end
    end

    assign pll_sync_s        = sync_q2_r[0];
    assign codec_done_sync_s = sync_q2_r[1];
    assign link_sync_s       = sync_q2_r[2];
    assign lin_sync_s        = sync_q2_r[3];
    assign lout_sync_s       = sync_q2_r[4];
    assign rx_ready_sync_s   = sync_q2_r[5];

    assign raw_present_s = !lin_sync_s && !lout_sync_s;
    assign stream_ok_s   = codec_done_sync_s && link_sync_s;

    // Jack debounce: count consecutive disagreeing cycles, flip the state
    // after DEBOUNCE_CYC of them; any agreeing cycle restarts the count.
    always_ff @(posedge clk_50M or negedge sys_rst) begin
        if (!sys_rst) begin
            deb_cnt_r      <= DEB_ZERO;
            jack_present_r <= 1'b0;
        end else if (raw_present_s == jack_present_r) begin
            deb_cnt_r      <= DEB_ZERO;
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r      <= DEB_ZERO;
            jack_present_r <= ~jack_present_r;
        end else begin
            deb_cnt_r      <= deb_cnt_r + DEB_ONE;
        end
    end

    // Next-state, retry-count and timer-enable decisions.
    always_comb begin
        state_nx_s = state_r;
        retry_nx_s = retry_cnt_r;
        tmr_run_s  = 1'b0;
        case (state_r)
            ST_RESET_HOLD: begin
                tmr_run_s = pll_sync_s;
                if (pll_sync_s && (tmr_r == HOLD_LAST)) begin
                    state_nx_s = ST_INIT;
                end else begin
                    state_nx_s = ST_RESET_HOLD;
                end
            end
            ST_INIT: begin
                tmr_run_s = 1'b1;
                if (!pll_sync_s) begin
                    state_nx_s = ST_RESET_HOLD;
                end else if (stream_ok_s) begin
                    state_nx_s = ST_WAIT_JACK;
                end else if (tmr_r == INIT_LAST) begin
                    if (retry_cnt_r < RETRY_LAST) begin
                        retry_nx_s = retry_cnt_r + 2'd1;
                        state_nx_s = ST_RESET_HOLD;
                    end else begin
                        state_nx_s = ST_FAULT;
                    end
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_WAIT_JACK: begin
                if (!pll_sync_s || !stream_ok_s) begin
                    state_nx_s = ST_RESET_HOLD;
                end else if (jack_present_r) begin
                    state_nx_s = ST_PRIME;
                end else begin
                    state_nx_s = ST_WAIT_JACK;
                end
            end
            ST_PRIME: begin
                if (!pll_sync_s || !stream_ok_s) begin
                    state_nx_s = ST_RESET_HOLD;
                end else if (!jack_present_r) begin
                    state_nx_s = ST_WAIT_JACK;
                end else if (rx_ready_sync_s) begin
                    retry_nx_s = 2'd0;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (!pll_sync_s || !stream_ok_s) begin
                    state_nx_s = ST_RESET_HOLD;
                end else if (!jack_present_r) begin
                    state_nx_s = ST_WAIT_JACK;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FAULT: begin
`ifdef AUDIO_LINK_AUTO_RECOVER_EN
                tmr_run_s = 1'b1;
                if (tmr_r == FAULT_LAST) begin
                    retry_nx_s = 2'd0;
                    state_nx_s = ST_RESET_HOLD;
                end else begin
                    state_nx_s = ST_FAULT;
                end
`else
                state_nx_s = ST_FAULT;
`endif
            end
            default: begin
                state_nx_s = ST_RESET_HOLD;
            end
        endcase
    end

    // Timer: cleared on every state change and whenever the state stops it.
    always_comb begin
        tmr_nx_s = TMR_ZERO;
        if (state_nx_s != state_r) begin
            tmr_nx_s = TMR_ZERO;
        end else if (tmr_run_s) begin
            tmr_nx_s = tmr_r + TMR_ONE;
        end else begin
            tmr_nx_s = TMR_ZERO;
        end
    end

    // State, timer, retry count and output registers (outputs decoded from
    // the next state so they line up with state_o).
    always_ff @(posedge clk_50M or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r       <= ST_RESET_HOLD;
            tmr_r         <= TMR_ZERO;
            retry_cnt_r   <= 2'd0;
            codec_rst_n_r <= 1'b0;
            eth_rst_n_r   <= 1'b0;
            tx_enable_r   <= 1'b0;
            rx_rd_en_r    <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            tmr_r         <= tmr_nx_s;
            retry_cnt_r   <= retry_nx_s;
            codec_rst_n_r <= (state_nx_s inside {ST_INIT, ST_WAIT_JACK, ST_PRIME, ST_RUN});
            eth_rst_n_r   <= (state_nx_s inside {ST_INIT, ST_WAIT_JACK, ST_PRIME, ST_RUN});
            tx_enable_r   <= (state_nx_s inside {ST_PRIME, ST_RUN});
            rx_rd_en_r    <= (state_nx_s == ST_RUN);
            fault_r       <= (state_nx_s == ST_FAULT);
        end
    end

    assign codec_rst_n       = codec_rst_n_r;
    assign eth_rst_n         = eth_rst_n_r;
    assign tx_enable         = tx_enable_r;
    assign rx_rd_en          = rx_rd_en_r;
    assign insert_detect_led = jack_present_r;
    assign state_o           = state_r;
    assign retry_cnt         = retry_cnt_r;
    assign fault             = fault_r;

endmodule

// File: tb/tb_audio_link_ctrl.sv
// Directed bench for audio_link_ctrl with DEBOUNCE_CYC=16, HOLD_CYC=8,
// INIT_TIMEOUT_CYC=100, RETRY_MAX=2, FAULT_WAIT_CYC=50.
// Inputs are driven 1 ns after a rising edge and outputs sampled at the same
// point; every input change reaches the FSM after the 2-flop synchroniser.

module tb_audio_link_ctrl;

    logic       clk_50M = 1'b0;
    logic       sys_rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       codec_init_done = 1'b0;
    logic       eth_link_up = 1'b0;
    logic       lin_detect = 1'b1;
    logic       lout_detect = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic       codec_rst_n;
    logic       eth_rst_n;
    logic       tx_enable;
    logic       rx_rd_en;
    logic       insert_detect_led;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk_50M = ~clk_50M;

    audio_link_ctrl #(
        .DEBOUNCE_CYC     (16),
        .HOLD_CYC         (8),
        .INIT_TIMEOUT_CYC (100),
        .RETRY_MAX        (2),
        .FAULT_WAIT_CYC   (50)
    ) dut (
        .clk_50M           (clk_50M),
        .sys_rst           (sys_rst),
        .pll_locked        (pll_locked),
        .codec_init_done   (codec_init_done),
        .eth_link_up       (eth_link_up),
        .lin_detect        (lin_detect),
        .lout_detect       (lout_detect),
        .rx_data_ready     (rx_data_ready),
        .codec_rst_n       (codec_rst_n),
        .eth_rst_n         (eth_rst_n),
        .tx_enable         (tx_enable),
        .rx_rd_en          (rx_rd_en),
        .insert_detect_led (insert_detect_led),
        .state_o           (state_o),
        .retry_cnt         (retry_cnt),
        .fault             (fault)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_path(input string tag, input logic [2:0] st, input logic crn,
                            input logic ern, input logic tx, input logic rx);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_codec_rst_n"}, 32'(codec_rst_n), 32'(crn));
        chk({tag, "_eth_rst_n"}, 32'(eth_rst_n), 32'(ern));
        chk({tag, "_tx_enable"}, 32'(tx_enable), 32'(tx));
        chk({tag, "_rx_rd_en"}, 32'(rx_rd_en), 32'(rx));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_path(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_led"}, 32'(insert_detect_led), 32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    // Safety net: the directed sequence is a few thousand cycles long.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: lock, jack present and RX data ready are applied under reset.
        sys_rst         = 1'b0;
        pll_locked      = 1'b1;
        lin_detect      = 1'b0;
        lout_detect     = 1'b0;
        rx_data_ready   = 1'b1;
        codec_init_done = 1'b0;
        eth_link_up     = 1'b0;
        tick(3);
        chk_reset_vals("rst");

        // 1. Nominal bring-up. Release is edge 0; lock seen after edge 2,
        //    hold timer ends 8 cycles later -> INIT on edge 10.
        sys_rst = 1'b1;
        tick(9);
        chk_path("t1_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_path("t1_init", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Jack debounce: 2 sync + 16 stable cycles -> present on edge 18.
        tick(7);
        chk("t1_led_pre", 32'(insert_detect_led), 32'd0);
        tick(1);
        chk("t1_led_on", 32'(insert_detect_led), 32'd1);
        // codec_done and link rise 20 cycles into INIT.
        tick(12);
        codec_init_done = 1'b1;
        eth_link_up     = 1'b1;
        tick(2);
        chk("t1_still_init", 32'(state_o), 32'd1);
        tick(1);
        chk_path("t1_wait", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_path("t1_prime", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_path("t1_run", 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t1_retry", 32'(retry_cnt), 32'd0);

        // 4. Headphone removed in RUN: jack drops after 2 + 16 cycles,
        //    FSM and enables follow one cycle later.
        lout_detect = 1'b1;
        tick(17);
        chk("t4_led_pre", 32'(insert_detect_led), 32'd1);
        chk("t4_run_pre", 32'(state_o), 32'd4);
        tick(1);
        chk("t4_led_off", 32'(insert_detect_led), 32'd0);
        chk("t4_tx_still", 32'(tx_enable), 32'd1);
        tick(1);
        chk_path("t4_wait", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        // 2. Bounce: 10-cycle windows never reach 16 stable cycles.
        for (int k = 0; k < 10; k++) begin
            lin_detect  = (k % 2 == 0) ? 1'b0 : 1'b1;
            lout_detect = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(10);
            chk($sformatf("t2_bounce%0d_state", k), 32'(state_o), 32'd2);
            chk($sformatf("t2_bounce%0d_led", k), 32'(insert_detect_led), 32'd0);
        end
        // Held low: 16 debounce cycles after the 2-flop sync, then PRIME, RUN.
        lin_detect  = 1'b0;
        lout_detect = 1'b0;
        tick(17);
        chk("t2_led_pre", 32'(insert_detect_led), 32'd0);
        chk("t2_wait_pre", 32'(state_o), 32'd2);
        tick(1);
        chk("t2_led_on", 32'(insert_detect_led), 32'd1);
        chk("t2_no_prime", 32'(state_o), 32'd2);
        tick(1);
        chk_path("t4_prime", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_path("t4_run", 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);

        // 5. One-cycle PLL glitch in RUN: seen after 2 sync edges.
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        chk("t5_run_pre", 32'(state_o), 32'd4);
        tick(1);
        chk_path("t5_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_retry", 32'(retry_cnt), 32'd0);
        tick(7);
        chk("t5_hold_end", 32'(state_o), 32'd0);
        tick(1);
        chk_path("t5_init", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(3);
        chk_path("t5_run", 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);

        // 3. Link lost and never returns: RESET_HOLD, then three 100-cycle
        //    INIT timeouts -> retry 1, 2, then FAULT.
        eth_link_up = 1'b0;
        tick(2);
        chk("t3_run_pre", 32'(state_o), 32'd4);
        tick(1);
        chk_path("t3_hold0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_retry0", 32'(retry_cnt), 32'd0);
        tick(8);
        chk("t3_init1", 32'(state_o), 32'd1);
        tick(99);
        chk("t3_init1_end", 32'(state_o), 32'd1);
        chk("t3_init1_retry", 32'(retry_cnt), 32'd0);
        tick(1);
        chk("t3_hold1", 32'(state_o), 32'd0);
        chk("t3_retry1", 32'(retry_cnt), 32'd1);
        tick(8);
        chk("t3_init2", 32'(state_o), 32'd1);
        tick(99);
        chk("t3_init2_end", 32'(state_o), 32'd1);
        tick(1);
        chk("t3_hold2", 32'(state_o), 32'd0);
        chk("t3_retry2", 32'(retry_cnt), 32'd2);
        tick(8);
        chk("t3_init3", 32'(state_o), 32'd1);
        tick(99);
        chk("t3_init3_end", 32'(state_o), 32'd1);
        chk("t3_init3_fault", 32'(fault), 32'd0);
        tick(1);
        chk_path("t3_fault", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_fault_flag", 32'(fault), 32'd1);
        chk("t3_fault_retry", 32'(retry_cnt), 32'd2);

`ifdef AUDIO_LINK_AUTO_RECOVER_EN
        // 6. Auto-recovery after 50 FAULT cycles.
        tick(49);
        chk("t6_fault_end", 32'(state_o), 32'd5);
        chk("t6_fault_flag_end", 32'(fault), 32'd1);
        tick(1);
        chk_path("t6_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_retry", 32'(retry_cnt), 32'd0);
        chk("t6_fault", 32'(fault), 32'd0);
`else
        // FAULT is sticky without auto-recovery.
        tick(1000);
        chk_path("t3_sticky", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_sticky_fault", 32'(fault), 32'd1);
        chk("t3_sticky_retry", 32'(retry_cnt), 32'd2);
`endif

        // Asynchronous reset mid-operation takes effect without a clock edge.
        sys_rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick(2);
        chk_reset_vals("async_rst_held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
